// File: rtl/pio_key_seq_pkg.sv
// pio_key_seq_pkg: sequencer state encoding and key PIO register offsets
package pio_key_seq_pkg;
   localparam logic [3:0] ST_RST       = 4'd0;
   localparam logic [3:0] ST_INIT_MASK = 4'd1;
   localparam logic [3:0] ST_INIT_CLR  = 4'd2;
   localparam logic [3:0] ST_IDLE      = 4'd3;
   localparam logic [3:0] ST_CAP_A     = 4'd4;
   localparam logic [3:0] ST_CAP_D     = 4'd5;
   localparam logic [3:0] ST_CLR       = 4'd6;
   localparam logic [3:0] ST_LVL_A     = 4'd7;
   localparam logic [3:0] ST_LVL_D     = 4'd8;
   localparam logic [1:0] OFS_DATA = 2'd0;
   localparam logic [1:0] OFS_MASK = 2'd2;
   localparam logic [1:0] OFS_EDGE = 2'd3;
endpackage

// File: rtl/pio_key_evt_fifo.sv
// pio_key_evt_fifo: show-ahead event FIFO; a push on full is taken when a pop frees a slot the same cycle
module pio_key_evt_fifo #(
   parameter int WIDTH = 20,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);
   localparam int AW = $clog2(DEPTH);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0] wr_ptr, rd_ptr;
   logic do_push, do_pop;
   assign empty   = wr_ptr == rd_ptr;
   assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign rdata   = mem[rd_ptr[AW-1:0]];
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (do_pop) rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
   end
endmodule

// File: rtl/pio_key_event_sequencer.sv
// pio_key_event_sequencer: autonomous Avalon-MM master that services a key PIO and queues timestamped key events
module pio_key_event_sequencer
   import pio_key_seq_pkg::*;
#(
   parameter int                   KEY_WIDTH     = 2,
   parameter logic [KEY_WIDTH-1:0] IRQ_MASK_INIT = {KEY_WIDTH{1'b1}},
   parameter int                   TS_WIDTH      = 16,
   parameter int                   FIFO_DEPTH    = 4
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 enable,
   input  logic                 irq,
   output logic [1:0]           m_address,
   output logic                 m_chipselect,
   output logic                 m_write_n,
   output logic [31:0]          m_writedata,
   input  logic [31:0]          m_readdata,
   output logic                 evt_valid,
   input  logic                 evt_ready,
   output logic [KEY_WIDTH-1:0] evt_edges,
   output logic [KEY_WIDTH-1:0] evt_level,
   output logic [TS_WIDTH-1:0]  evt_time,
   output logic [7:0]           drop_count,
   output logic                 busy
);
   localparam int EW = 2*KEY_WIDTH + TS_WIDTH;
   logic [3:0] state, state_nx;
   logic [KEY_WIDTH-1:0] cap, rd_key, wr_val;
   logic [TS_WIDTH-1:0] ts, ts_cap;
   logic wr, rd, push, full, empty, drop, unused_rd;
   logic [EW-1:0] evt_data;
   assign rd_key    = m_readdata[KEY_WIDTH-1:0];
   assign unused_rd = ^m_readdata[31:KEY_WIDTH];
   always_comb begin
      state_nx = state;
      case (state)
         ST_RST:       state_nx = ST_INIT_MASK;
         ST_INIT_MASK: state_nx = ST_INIT_CLR;
         ST_INIT_CLR:  state_nx = ST_IDLE;
         ST_IDLE:      state_nx = (irq && enable) ? ST_CAP_A : ST_IDLE;
         ST_CAP_A:     state_nx = ST_CAP_D;
         ST_CAP_D:     state_nx = (rd_key == '0) ? ST_IDLE : ST_CLR;
         ST_CLR:       state_nx = ST_LVL_A;
         ST_LVL_A:     state_nx = ST_LVL_D;
         ST_LVL_D:     state_nx = ST_IDLE;
         default:      state_nx = ST_RST;
      endcase
   end
   assign wr           = state inside {ST_INIT_MASK, ST_INIT_CLR, ST_CLR};
   assign rd           = state inside {ST_CAP_A, ST_LVL_A};
   assign m_chipselect = wr || rd;
   assign m_write_n    = !wr;
   assign m_address    = (state == ST_INIT_MASK) ? OFS_MASK :
                         (state inside {ST_INIT_CLR, ST_CAP_A, ST_CLR}) ? OFS_EDGE : OFS_DATA;
   // CLR writes back only the bits that were captured, so later edges survive
   assign wr_val       = (state == ST_INIT_MASK) ? IRQ_MASK_INIT :
                         (state == ST_INIT_CLR) ? {KEY_WIDTH{1'b1}} :
                         (state == ST_CLR) ? cap : '0;
   assign m_writedata  = 32'(wr_val);
   assign busy         = state != ST_IDLE;
   assign push         = state == ST_LVL_D;
   assign drop         = push && full && !evt_ready;
   assign evt_data     = {cap, rd_key, ts_cap};
   assign evt_valid    = !empty;
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state      <= ST_RST;
         ts         <= '0;
         cap        <= '0;
         ts_cap     <= '0;
         drop_count <= '0;
      end else begin
         state <= state_nx;
         ts    <= ts + TS_WIDTH'(1);
         if (state == ST_CAP_D) begin
            cap    <= rd_key;
            ts_cap <= ts;
         end
         if (drop && drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
      end
   end
   pio_key_evt_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk(clk),
      .reset_n(reset_n),
      .push(push),
      .pop(evt_ready),
      .wdata(evt_data),
      .rdata({evt_edges, evt_level, evt_time}),
      .full(full),
      .empty(empty)
   );
endmodule

// File: tb/tb_pio_key_event_sequencer.sv
// tb_pio_key_event_sequencer: key PIO model, transaction-level reference model and directed scenarios
module tb_pio_key_event_sequencer;
   typedef struct {logic [1:0] e; logic [1:0] l; logic [15:0] t;} ev_t;
   logic clk = 0, reset_n = 0, enable = 1, evt_ready = 0, spur = 0;
   logic irq, m_chipselect, m_write_n, evt_valid, busy;
   logic [1:0] m_address, evt_edges, evt_level;
   logic [31:0] m_writedata, m_readdata;
   logic [15:0] evt_time;
   logic [7:0] drop_count;
   logic [1:0] keys = 2'b01, edge_set = 0, pio_edge = 0, pio_mask = 0;
   logic [31:0] pio_rd = 0;
   int ncmp = 0, nbad = 0;
   int rel = 0, svc = -1;
   bit armed = 0, popped, was_full;
   logic [1:0] c1, mcap = 0, mlvl;
   logic [15:0] mts = 0, mtime;
   logic [7:0] mdrop = 0;
   ev_t mq[$];
   logic ecs, ewn;
   logic [1:0] eaddr;
   logic [31:0] ewd;

   pio_key_event_sequencer dut (
      .clk(clk), .reset_n(reset_n), .enable(enable), .irq(irq),
      .m_address(m_address), .m_chipselect(m_chipselect), .m_write_n(m_write_n),
      .m_writedata(m_writedata), .m_readdata(m_readdata),
      .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_edges(evt_edges),
      .evt_level(evt_level), .evt_time(evt_time), .drop_count(drop_count), .busy(busy)
   );

   always #5 clk = ~clk;

   // key PIO: registered readdata, edge capture cleared by writing ones (clear wins)
   assign irq = (|(pio_edge & pio_mask)) | spur;
   assign m_readdata = pio_rd;
   always @(posedge clk) begin
      if (m_chipselect && m_write_n)
         pio_rd <= (m_address == 2'd0) ? {30'b0, keys} : (m_address == 2'd2) ? {30'b0, pio_mask} :
                   (m_address == 2'd3) ? {30'b0, pio_edge} : 32'b0;
      if (m_chipselect && !m_write_n && m_address == 2'd2) pio_mask <= m_writedata[1:0];
      pio_edge <= (pio_edge | edge_set) & ~((m_chipselect && !m_write_n && m_address == 2'd3) ? m_writedata[1:0] : 2'b0);
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      ncmp++;
      if (act !== exp) begin
         nbad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // reference model: rel = cycles since reset release (caps at 3), svc = cycles into a service (-1 none)
   always @(posedge clk) begin
      if (!reset_n) begin
         armed = 1; rel = 0; svc = -1; mq.delete(); mdrop = 0; mts = 0;
      end else begin
         was_full = mq.size() == 4;
         popped = evt_ready && mq.size() > 0;
         if (popped) void'(mq.pop_front());
         case (svc)
            -1: if (rel >= 3 && irq && enable) svc = 0;
            0: begin c1 = pio_edge; svc = 1; end
            1: begin mcap = c1; mtime = mts; svc = (c1 == 2'b00) ? -1 : 2; end
            2: svc = 3;
            3: begin mlvl = keys; svc = 4; end
            4: begin
               if (!was_full || popped) mq.push_back('{mcap, mlvl, mtime});
               else if (mdrop != 8'hFF) mdrop++;
               svc = -1;
            end
            default: svc = -1;
         endcase
         if (rel < 3) rel++;
         mts++;
      end
   end

   always @(negedge clk) if (armed) begin
      ecs   = rel == 1 || rel == 2 || svc == 0 || svc == 2 || svc == 3;
      ewn   = !(rel == 1 || rel == 2 || svc == 2);
      eaddr = (rel == 1) ? 2'd2 : (rel == 2 || svc == 0 || svc == 2) ? 2'd3 : 2'd0;
      ewd   = (rel == 1 || rel == 2) ? 32'd3 : (svc == 2) ? {30'b0, mcap} : 32'd0;
      chk("m_chipselect", m_chipselect, ecs);
      chk("m_write_n", m_write_n, ewn);
      chk("m_address", m_address, eaddr);
      chk("m_writedata", m_writedata, ewd);
      chk("busy", busy, (rel < 3 || svc >= 0));
      chk("drop_count", drop_count, mdrop);
      chk("evt_valid", evt_valid, mq.size() > 0);
      if (mq.size() > 0) begin
         chk("evt_edges", evt_edges, mq[0].e);
         chk("evt_level", evt_level, mq[0].l);
         chk("evt_time", evt_time, mq[0].t);
      end
   end

   task automatic pulse(input logic [1:0] s);
      edge_set = s;
      @(negedge clk);
      edge_set = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: run exceeded its time limit");
      $fatal(1);
   end

   initial begin
      repeat (3) @(negedge clk);
      chk("lit reset busy", busy, 1);
      chk("lit reset evt_valid", evt_valid, 0);
      reset_n = 1;
      @(negedge clk);
      chk("lit init mask addr", {m_chipselect, m_write_n, m_address, m_writedata[1:0]}, 6'b10_10_11);
      @(negedge clk);
      chk("lit init clr addr", {m_chipselect, m_write_n, m_address, m_writedata[1:0]}, 6'b10_11_11);
      @(negedge clk);
      chk("lit idle busy", busy, 0);
      chk("lit pio mask", pio_mask, 2'b11);
      repeat (58) @(negedge clk);
      pulse(2'b01);
      @(negedge clk);
      chk("lit cap read", {m_chipselect, m_write_n, m_address}, 4'b1111);
      repeat (2) @(negedge clk);
      chk("lit irq before clr", irq, 1);
      chk("lit clr write", {m_write_n, m_writedata[1:0]}, 3'b001);
      @(negedge clk);
      chk("lit irq after clr", irq, 0);
      @(negedge clk);
      chk("lit evt_valid before push", evt_valid, 0);
      @(negedge clk);
      chk("lit evt fields", {evt_valid, evt_edges, evt_level, evt_time}, {1'b1, 2'b01, 2'b01, 16'h0040});
      evt_ready = 1;
      @(negedge clk);
      evt_ready = 0;
      repeat (2) @(negedge clk);
      spur = 1;
      @(negedge clk);
      spur = 0;
      repeat (2) @(negedge clk);
      chk("lit spurious idle", busy, 0);
      chk("lit spurious no push", evt_valid, 0);
      enable = 0;
      pulse(2'b01);
      repeat (4) @(negedge clk);
      chk("lit disabled idle", busy, 0);
      enable = 1;
      repeat (8) @(negedge clk);
      chk("lit enabled event", {evt_valid, evt_edges}, 3'b101);
      evt_ready = 1;
      @(negedge clk);
      evt_ready = 0;
      keys = 2'b10;
      for (int i = 0; i < 5; i++) begin
         pulse(2'b01);
         repeat (7) @(negedge clk);
      end
      chk("lit overflow drop", drop_count, 1);
      pulse(2'b10);
      repeat (5) @(negedge clk);
      evt_ready = 1;
      @(negedge clk);
      evt_ready = 0;
      chk("lit push with pop drop", drop_count, 1);
      evt_ready = 1;
      repeat (5) @(negedge clk);
      evt_ready = 0;
      chk("lit drained", evt_valid, 0);
      keys = 2'b11;
      pulse(2'b01);
      repeat (2) @(negedge clk);
      pulse(2'b10);
      chk("lit partial clr", {m_write_n, m_writedata[1:0]}, 3'b001);
      @(negedge clk);
      chk("lit irq stays", irq, 1);
      repeat (12) @(negedge clk);
      chk("lit first of two", {evt_valid, evt_edges}, 3'b101);
      pulse(2'b01);
      repeat (4) @(negedge clk);
      reset_n = 0;
      @(negedge clk);
      chk("lit mid reset bus", m_chipselect, 0);
      chk("lit mid reset fifo", evt_valid, 0);
      chk("lit mid reset busy", busy, 1);
      chk("lit mid reset drop", drop_count, 0);
      reset_n = 1;
      @(negedge clk);
      chk("lit replay mask", {m_chipselect, m_write_n, m_address}, 4'b1010);
      repeat (2) @(negedge clk);
      chk("lit replay idle", busy, 0);
      repeat (3) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
      $finish;
   end
endmodule
